// File: rtl/mult_arb_pkg.sv
// Shared state encoding and defaults for the multiplier arbiter.
package mult_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} arb_state_t;

   localparam int unsigned DEF_TIMEOUT = 15;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   input  logic                    en,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] gnt_idx
);

   localparam int unsigned IW = $clog2(NREQ);

   logic found;

   // Pass 0 scans ptr..NREQ-1, pass 1 wraps around to 0..ptr-1.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      if (en) begin
         for (int unsigned pass = 0; pass < 2; pass++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
               if (!found && req[i] && (pass == 1 || IW'(i) >= ptr)) begin
                  found   = 1'b1;
                  gnt[i]  = 1'b1;
                  gnt_idx = IW'(i);
               end
            end
         end
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential multiplier among NREQ requesters with round-robin grants,
// returning each product tagged with the winner's id; sticky err on mult timeout.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned W       = 4,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*W-1:0]       req_mcand,
   input  logic [NREQ*W-1:0]       req_mplier,
   output logic [NREQ-1:0]         req_ready,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [2*W-1:0]          rsp_product,
   output logic                    mult_start,
   output logic [W-1:0]            mult_mcand,
   output logic [W-1:0]            mult_mplier,
   input  logic                    mult_rdy,
   input  logic [2*W-1:0]          mult_product,
   output logic                    err
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   arb_state_t     state_q, state_d;
   logic [IW-1:0]  ptr_q, ptr_d;
   logic [IW-1:0]  id_q, id_d;
   logic [W-1:0]   mcand_q, mcand_d;
   logic [W-1:0]   mplier_q, mplier_d;
   logic [2*W-1:0] prod_q, prod_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           err_q, err_d;
   logic [NREQ-1:0] gnt;
   logic [IW-1:0]  gnt_idx;
   logic           arb_en;

   assign arb_en = (state_q == IDLE) && mult_rdy && !reset;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req     (req_valid),
      .ptr     (ptr_q),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      id_d     = id_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            if (|gnt) begin
               for (int unsigned i = 0; i < NREQ; i++) begin
                  if (gnt[i]) begin
                     mcand_d  = req_mcand[i*W +: W];
                     mplier_d = req_mplier[i*W +: W];
                  end
               end
               id_d    = gnt_idx;
               ptr_d   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = BUSY;
         end
         BUSY: begin
            // cnt_q == 0 marks the blanking cycle where mult_rdy is still the stale idle value.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q != '0 && mult_rdy) begin
               prod_d  = mult_product;
               state_d = RESP;
            end else if (cnt_d == CW'(TIMEOUT)) begin
               err_d   = 1'b1;
               prod_d  = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         id_q     <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   assign req_ready   = gnt;
   assign rsp_valid   = (state_q == RESP);
   assign rsp_id      = id_q;
   assign rsp_product = prod_q;
   assign mult_start  = (state_q == ISSUE);
   assign mult_mcand  = mcand_q;
   assign mult_mplier = mplier_q;
   assign err         = err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter with a behavioural 4-cycle shift-add multiplier and a
// round-robin reference model.
module tb_mult_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 4;
   localparam int TMO  = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [15:0] req_mcand, req_mplier;
   logic [3:0]  req_ready;
   logic        rsp_valid, rsp_ready;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_product;
   logic        mult_start;
   logic [3:0]  mult_mcand, mult_mplier;
   logic        mult_rdy;
   logic [7:0]  mult_product;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;
   int m_ptr   = 0;
   int a[4];
   int b[4];
   int start_cnt = 0;
   int gnt_cnt   = 0;
   int m_busy    = 0;
   bit m_stub    = 1'b0;
   logic [7:0] m_prod = '0;

   always #5 clk = ~clk;

   mult_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TMO)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_mcand    (req_mcand),
      .req_mplier   (req_mplier),
      .req_ready    (req_ready),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_product  (rsp_product),
      .mult_start   (mult_start),
      .mult_mcand   (mult_mcand),
      .mult_mplier  (mult_mplier),
      .mult_rdy     (mult_rdy),
      .mult_product (mult_product),
      .err          (err)
   );

   // Multiplier: busy 4 cycles after start, product formed from the live operand inputs.
   always @(posedge clk) begin
      if (mult_start) m_busy <= 4;
      else if (m_busy != 0) begin
         m_busy <= m_busy - 1;
         if (m_busy == 1) m_prod <= 8'(mult_mcand) * 8'(mult_mplier);
      end
      if (mult_start) start_cnt <= start_cnt + 1;
      if (|(req_valid & req_ready)) gnt_cnt <= gnt_cnt + 1;
   end
   assign mult_rdy     = (m_busy == 0) && !m_stub;
   assign mult_product = m_prod;

   function automatic int ref_pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++) begin
         int j;
         j = (p + k) % 4;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic set_ops();
      for (int i = 0; i < 4; i++) begin
         req_mcand[i*4 +: 4]  = 4'(a[i]);
         req_mplier[i*4 +: 4] = 4'(b[i]);
      end
   endtask

   task automatic rand_ops();
      for (int i = 0; i < 4; i++) begin
         a[i] = int'($urandom_range(0, 15));
         b[i] = int'($urandom_range(0, 15));
      end
      set_ops();
   endtask

   task automatic apply_reset();
      adv();
      reset = 1'b1; req_valid = '0; rsp_ready = 1'b0; m_stub = 1'b0;
      adv();
      adv();
      reset = 1'b0;
      m_ptr = 0;
      smp();
   endtask

   task automatic wait_grant(output int gidx);
      gidx = -1;
      for (int k = 0; k < 40; k++) begin
         if (req_ready != '0) begin
            for (int i = 0; i < 4; i++) if (req_ready[i]) gidx = i;
            return;
         end
         adv();
         smp();
      end
   endtask

   task automatic wait_resp(output int waited);
      waited = -1;
      for (int k = 1; k <= 40; k++) begin
         adv();
         smp();
         if (rsp_valid === 1'b1) begin
            waited = k;
            return;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      adv();
      adv();
      smp();
      n_tests++; if (req_ready !== 4'b0)   begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
      n_tests++; if (rsp_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
      n_tests++; if (rsp_id !== 2'd0)      begin n_fail++; $display("FAIL rst_rsp_id: got %0d expected 0", rsp_id); end
      n_tests++; if (rsp_product !== 8'd0) begin n_fail++; $display("FAIL rst_rsp_product: got %0d expected 0", rsp_product); end
      n_tests++; if (mult_start !== 1'b0)  begin n_fail++; $display("FAIL rst_mult_start: got %b expected 0", mult_start); end
      n_tests++; if (mult_mcand !== 4'd0 || mult_mplier !== 4'd0) begin
         n_fail++; $display("FAIL rst_operands: got %0d,%0d expected 0,0", mult_mcand, mult_mplier);
      end
      n_tests++; if (err !== 1'b0)         begin n_fail++; $display("FAIL rst_err: got %b expected 0", err); end
      adv();
      reset = 1'b0;
      smp();
      n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0) begin
         n_fail++; $display("FAIL rst_release: rsp_valid=%b req_ready=%b expected 0,0000", rsp_valid, req_ready);
      end
      m_ptr = 0;
   endtask

   task automatic test_single();
      int g, w, s0;
      adv();
      a[2] = 3; b[2] = 5; set_ops();
      req_valid = 4'b0100; rsp_ready = 1'b1;
      smp();
      s0 = start_cnt;
      wait_grant(g);
      n_tests++; if (g !== 2) begin n_fail++; $display("FAIL single_winner: got %0d expected 2", g); end
      n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_onehot: got %b expected 0100", req_ready); end
      m_ptr = 3;
      adv();
      smp();
      n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_once: got %b expected 0000", req_ready); end
      n_tests++; if (mult_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b expected 1", mult_start); end
      adv();
      req_valid = '0;
      smp();
      n_tests++; if (mult_start !== 1'b0) begin n_fail++; $display("FAIL single_start_pulse: got %b expected 0", mult_start); end
      wait_resp(w);
      n_tests++; if (w + 2 !== 7) begin n_fail++; $display("FAIL single_latency: got %0d expected 7", w + 2); end
      n_tests++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_id: got %0d expected 2", rsp_id); end
      n_tests++; if (rsp_product !== 8'd15) begin n_fail++; $display("FAIL single_product: got %0d expected 15", rsp_product); end
      n_tests++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL single_start_count: got %0d expected 1", start_cnt - s0); end
      adv();
      smp();
   endtask

   task automatic test_fairness();
      int g, w, e, g0, s0;
      apply_reset();
      adv();
      for (int i = 0; i < 4; i++) begin a[i] = i + 1; b[i] = i + 2; end
      set_ops();
      req_valid = 4'hF; rsp_ready = 1'b1;
      g0 = gnt_cnt; s0 = start_cnt;
      smp();
      for (int op = 0; op < 5; op++) begin
         wait_grant(g);
         e = ref_pick(4'hF, m_ptr);
         n_tests++; if (g !== e) begin n_fail++; $display("FAIL fair_order: op %0d got %0d expected %0d", op, g, e); end
         m_ptr = (e + 1) % 4;
         wait_resp(w);
         n_tests++; if (w + 0 !== 7) begin n_fail++; $display("FAIL fair_latency: op %0d got %0d expected 7", op, w); end
         n_tests++; if (int'(rsp_id) !== e || int'(rsp_product) !== (e + 1) * (e + 2)) begin
            n_fail++; $display("FAIL fair_result: op %0d got id %0d prod %0d expected id %0d prod %0d",
                               op, rsp_id, rsp_product, e, (e + 1) * (e + 2));
         end
         adv();
         if (op == 4) req_valid = '0;
         smp();
      end
      n_tests++; if (gnt_cnt - g0 !== 5) begin n_fail++; $display("FAIL fair_grant_count: got %0d expected 5", gnt_cnt - g0); end
      n_tests++; if (start_cnt - s0 !== 5) begin n_fail++; $display("FAIL fair_start_count: got %0d expected 5", start_cnt - s0); end
   endtask

   task automatic test_backpressure();
      int r, g, w, e, g0, ep;
      for (int it = 0; it < 2; it++) begin
         adv();
         rand_ops();
         r = int'($urandom_range(0, 3));
         req_valid = 4'(1 << r); rsp_ready = 1'b0;
         smp();
         wait_grant(g);
         n_tests++; if (g !== r) begin n_fail++; $display("FAIL bp_winner: got %0d expected %0d", g, r); end
         m_ptr = (r + 1) % 4;
         ep = a[r] * b[r];
         adv();
         req_valid = 4'hF;
         smp();
         wait_resp(w);
         n_tests++; if (w + 1 !== 7) begin n_fail++; $display("FAIL bp_latency: got %0d expected 7", w + 1); end
         g0 = gnt_cnt;
         for (int c = 0; c < 5; c++) begin
            adv();
            smp();
            n_tests++; if (rsp_valid !== 1'b1 || int'(rsp_id) !== r || int'(rsp_product) !== ep) begin
               n_fail++; $display("FAIL bp_hold: cycle %0d got v=%b id=%0d prod=%0d expected v=1 id=%0d prod=%0d",
                                  c, rsp_valid, rsp_id, rsp_product, r, ep);
            end
            n_tests++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL bp_no_grant: got %b expected 0000", req_ready); end
         end
         n_tests++; if (gnt_cnt !== g0) begin n_fail++; $display("FAIL bp_grant_count: got %0d expected %0d", gnt_cnt, g0); end
         adv();
         rsp_ready = 1'b1;
         smp();
         adv();
         smp();
         e = ref_pick(4'hF, m_ptr);
         n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b expected 0", rsp_valid); end
         n_tests++; if (req_ready !== 4'(1 << e)) begin n_fail++; $display("FAIL bp_next_grant: got %b expected %b", req_ready, 4'(1 << e)); end
         m_ptr = (e + 1) % 4;
         ep = a[e] * b[e];
         adv();
         req_valid = '0;
         smp();
         wait_resp(w);
         n_tests++; if (int'(rsp_id) !== e || int'(rsp_product) !== ep) begin
            n_fail++; $display("FAIL bp_next_result: got id %0d prod %0d expected id %0d prod %0d", rsp_id, rsp_product, e, ep);
         end
         adv();
         smp();
      end
   endtask

   task automatic test_edge_values();
      int ta[3] = '{15, 0, 15};
      int tb[3] = '{15, 9, 1};
      int tp[3] = '{225, 0, 15};
      int r, g, w;
      for (int k = 0; k < 3; k++) begin
         adv();
         rand_ops();
         r = int'($urandom_range(0, 3));
         a[r] = ta[k]; b[r] = tb[k]; set_ops();
         req_valid = 4'(1 << r); rsp_ready = 1'b1;
         smp();
         wait_grant(g);
         n_tests++; if (g !== r) begin n_fail++; $display("FAIL edge_winner: case %0d got %0d expected %0d", k, g, r); end
         m_ptr = (r + 1) % 4;
         adv();
         rand_ops();
         req_valid = '0;
         smp();
         wait_resp(w);
         n_tests++; if (w + 1 !== 7) begin n_fail++; $display("FAIL edge_latency: case %0d got %0d expected 7", k, w + 1); end
         n_tests++; if (int'(rsp_product) !== tp[k] || int'(rsp_id) !== r) begin
            n_fail++; $display("FAIL edge_result: case %0d got id %0d prod %0d expected id %0d prod %0d",
                               k, rsp_id, rsp_product, r, tp[k]);
         end
         adv();
         smp();
      end
   endtask

   task automatic test_random_traffic();
      logic [3:0] mask;
      int g, w, e, ep, d;
      for (int n = 0; n < 10; n++) begin
         adv();
         rand_ops();
         mask = 4'($urandom_range(1, 15));
         req_valid = mask; rsp_ready = 1'b0;
         smp();
         e = ref_pick(mask, m_ptr);
         wait_grant(g);
         n_tests++; if (g !== e) begin n_fail++; $display("FAIL rand_winner: op %0d mask %b got %0d expected %0d", n, mask, g, e); end
         m_ptr = (e + 1) % 4;
         ep = a[e] * b[e];
         adv();
         rand_ops();
         req_valid = 4'($urandom_range(0, 15));
         smp();
         wait_resp(w);
         n_tests++; if (w + 1 !== 7 || int'(rsp_id) !== e || int'(rsp_product) !== ep) begin
            n_fail++; $display("FAIL rand_result: op %0d got lat %0d id %0d prod %0d expected lat 7 id %0d prod %0d",
                               n, w + 1, rsp_id, rsp_product, e, ep);
         end
         d = int'($urandom_range(0, 3));
         for (int c = 0; c < d; c++) begin adv(); smp(); end
         adv();
         rsp_ready = 1'b1;
         req_valid = '0;
         smp();
         adv();
         rsp_ready = 1'b0;
         smp();
         n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rand_accept: op %0d got %b expected 0", n, rsp_valid); end
      end
   endtask

   task automatic test_timeout();
      int g, w, e, ep;
      adv();
      a[1] = 7; b[1] = 3; set_ops();
      req_valid = 4'b0010; rsp_ready = 1'b0; m_stub = 1'b1;
      smp();
      for (int c = 0; c < 3; c++) begin
         n_tests++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL to_idle_wait: got %b expected 0000", req_ready); end
         adv();
         smp();
      end
      adv();
      m_stub = 1'b0;
      smp();
      wait_grant(g);
      e = ref_pick(4'b0010, m_ptr);
      n_tests++; if (g !== e) begin n_fail++; $display("FAIL to_winner: got %0d expected %0d", g, e); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_before: got %b expected 0", err); end
      m_ptr = (e + 1) % 4;
      adv();
      m_stub = 1'b1;
      req_valid = '0;
      smp();
      wait_resp(w);
      n_tests++; if (w + 1 !== TMO + 2) begin n_fail++; $display("FAIL to_latency: got %0d expected %0d", w + 1, TMO + 2); end
      n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b expected 1", err); end
      n_tests++; if (rsp_product !== 8'd0 || rsp_id !== 2'd1) begin
         n_fail++; $display("FAIL to_result: got id %0d prod %0d expected id 1 prod 0", rsp_id, rsp_product);
      end
      adv();
      rsp_ready = 1'b1;
      m_stub = 1'b0;
      smp();
      adv();
      smp();
      n_tests++; if (rsp_valid !== 1'b0 || err !== 1'b1) begin
         n_fail++; $display("FAIL to_sticky: got v=%b err=%b expected v=0 err=1", rsp_valid, err);
      end
      adv();
      rand_ops();
      req_valid = 4'b1000;
      smp();
      wait_grant(g);
      n_tests++; if (g !== 3) begin n_fail++; $display("FAIL to_after_winner: got %0d expected 3", g); end
      m_ptr = 0;
      ep = a[3] * b[3];
      adv();
      req_valid = '0;
      smp();
      wait_resp(w);
      n_tests++; if (int'(rsp_product) !== ep || err !== 1'b1) begin
         n_fail++; $display("FAIL to_after_result: got prod %0d err %b expected prod %0d err 1", rsp_product, err, ep);
      end
      adv();
      smp();
   endtask

   task automatic test_reset_mid_op();
      int r, g, w, ep;
      adv();
      rand_ops();
      r = int'($urandom_range(1, 3));
      req_valid = 4'(1 << r); rsp_ready = 1'b1;
      smp();
      wait_grant(g);
      n_tests++; if (g !== r) begin n_fail++; $display("FAIL rm_winner: got %0d expected %0d", g, r); end
      adv(); req_valid = '0; smp();
      adv(); smp();
      adv();
      reset = 1'b1;
      req_valid = 4'hF;
      smp();
      adv();
      smp();
      n_tests++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_product !== 8'd0) begin
         n_fail++; $display("FAIL rm_rsp_reset: got v=%b id=%0d prod=%0d expected 0,0,0", rsp_valid, rsp_id, rsp_product);
      end
      n_tests++; if (mult_start !== 1'b0 || mult_mcand !== 4'd0 || mult_mplier !== 4'd0) begin
         n_fail++; $display("FAIL rm_mult_reset: got start=%b ops=%0d,%0d expected 0,0,0", mult_start, mult_mcand, mult_mplier);
      end
      n_tests++; if (err !== 1'b0 || req_ready !== 4'b0) begin
         n_fail++; $display("FAIL rm_err_ready_reset: got err=%b ready=%b expected 0,0000", err, req_ready);
      end
      m_ptr = 0;
      adv();
      reset = 1'b0;
      smp();
      n_tests++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL rm_wait_rdy: got %b expected 0000", req_ready); end
      wait_grant(g);
      n_tests++; if (g !== ref_pick(4'hF, m_ptr)) begin n_fail++; $display("FAIL rm_first_grant: got %0d expected %0d", g, ref_pick(4'hF, m_ptr)); end
      m_ptr = 1;
      ep = a[0] * b[0];
      adv();
      req_valid = '0;
      smp();
      wait_resp(w);
      n_tests++; if (w + 1 !== 7 || rsp_id !== 2'd0 || int'(rsp_product) !== ep) begin
         n_fail++; $display("FAIL rm_next_op: got lat %0d id %0d prod %0d expected lat 7 id 0 prod %0d", w + 1, rsp_id, rsp_product, ep);
      end
      adv();
      smp();
   endtask

   initial begin
      reset = 1'b1;
      req_valid = '0;
      req_mcand = '0;
      req_mplier = '0;
      rsp_ready = 1'b0;
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_edge_values();
      test_random_traffic();
      test_timeout();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
      $fatal(1, "watchdog expired");
   end

endmodule
